// File: rtl/matmul_bt_pkg.sv
// Shared types, widths and default dimensions for the transposed-B matmul path.
package matmul_bt_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_K      = 4;
  localparam int DEF_N      = 4;
  localparam int DEF_M      = 4;

  typedef enum logic [1:0] {
    LOAD_B = 2'd0,
    LOAD_A = 2'd1,
    STREAM = 2'd2
  } seq_state_e;

  // Counter width for an index range of x entries, never narrower than one bit.
  function automatic int CNT_W(input int x);
    if (x > 1) begin
      return $clog2(x);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/matmul_bt_operand_buf.sv
// Operand register file: one synchronous write port, one combinational read port.
module matmul_bt_operand_buf
  import matmul_bt_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  DEPTH  = DEF_K,
  localparam int AW     = CNT_W(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/matmul_bt_operand_sequencer.sv
// Buffers B (N x K) and one A row, then replays aligned (a[k], b[j][k]) pairs
// with end-of-dot-product, end-of-row and end-of-matrix flags.
module matmul_bt_operand_sequencer
  import matmul_bt_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int K      = DEF_K,
  parameter int N      = DEF_N,
  parameter int M      = DEF_M
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              last_k,
  output logic              last_row,
  output logic              last_mat
);

  localparam int NK = N * K;
  localparam int WW = CNT_W(NK);
  localparam int KW = CNT_W(K);
  localparam int NW = CNT_W(N);
  localparam int MW = CNT_W(M);

  localparam logic [WW-1:0] NK_LAST   = WW'(NK - 1);
  localparam logic [WW-1:0] K_WR_LAST = WW'(K - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(K - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(N - 1);
  localparam logic [MW-1:0] M_LAST    = MW'(M - 1);

  seq_state_e        state_r, state_s;
  logic [WW-1:0]     wr_idx_r, wr_idx_s;
  logic [KW-1:0]     k_r, k_s;
  logic [NW-1:0]     j_r, j_s;
  logic [MW-1:0]     i_r, i_s;
  logic              valid_r, valid_s;
  logic [DATA_W-1:0] data_a_r, data_a_s;
  logic [DATA_W-1:0] data_b_r, data_b_s;
  logic              last_k_r, last_k_s;
  logic              last_row_r, last_row_s;
  logic              last_mat_r, last_mat_s;

  logic              in_ready_s;
  logic              in_fire_s;
  logic              issue_s;
  logic              a_we_s;
  logic              b_we_s;
  logic [KW-1:0]     a_waddr_s;
  logic [WW-1:0]     b_raddr_s;
  logic [DATA_W-1:0] a_rdata_s;
  logic [DATA_W-1:0] b_rdata_s;

  assign in_ready_s = (state_r == LOAD_B) || (state_r == LOAD_A);
  assign in_fire_s  = in_valid && in_ready_s;
  assign issue_s    = (state_r == STREAM) && (!valid_r || ready_out);
  assign a_waddr_s  = KW'(wr_idx_r);
  assign b_raddr_s  = WW'(int'(j_r) * K + int'(k_r));

  matmul_bt_operand_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (NK)
  ) u_b_buf (
    .clk     (clk),
    .wr_en   (b_we_s),
    .wr_addr (wr_idx_r),
    .wr_data (in_data),
    .rd_addr (b_raddr_s),
    .rd_data (b_rdata_s)
  );

  matmul_bt_operand_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (K)
  ) u_a_buf (
    .clk     (clk),
    .wr_en   (a_we_s),
    .wr_addr (a_waddr_s),
    .wr_data (in_data),
    .rd_addr (k_r),
    .rd_data (a_rdata_s)
  );

  // Next-state, counter and output-register decode.
  always_comb begin
    state_s    = state_r;
    wr_idx_s   = wr_idx_r;
    k_s        = k_r;
    j_s        = j_r;
    i_s        = i_r;
    valid_s    = valid_r;
    data_a_s   = data_a_r;
    data_b_s   = data_b_r;
    last_k_s   = last_k_r;
    last_row_s = last_row_r;
    last_mat_s = last_mat_r;
    a_we_s     = 1'b0;
    b_we_s     = 1'b0;

    case (state_r)
      LOAD_B: begin
        // The last pair of the previous matrix may still be waiting here.
        if (ready_out) begin
          valid_s = 1'b0;
        end else begin
          valid_s = valid_r;
        end
        if (in_fire_s) begin
          b_we_s = 1'b1;
          if (wr_idx_r == NK_LAST) begin
            wr_idx_s = {WW{1'b0}};
            state_s  = LOAD_A;
          end else begin
            wr_idx_s = wr_idx_r + WW'(1);
          end
        end else begin
          wr_idx_s = wr_idx_r;
        end
      end

      LOAD_A: begin
        if (ready_out) begin
          valid_s = 1'b0;
        end else begin
          valid_s = valid_r;
        end
        if (in_fire_s) begin
          a_we_s = 1'b1;
          if (wr_idx_r == K_WR_LAST) begin
            wr_idx_s = {WW{1'b0}};
            k_s      = {KW{1'b0}};
            j_s      = {NW{1'b0}};
            state_s  = STREAM;
          end else begin
            wr_idx_s = wr_idx_r + WW'(1);
          end
        end else begin
          wr_idx_s = wr_idx_r;
        end
      end

      STREAM: begin
        if (issue_s) begin
          valid_s    = 1'b1;
          data_a_s   = a_rdata_s;
          data_b_s   = b_rdata_s;
          last_k_s   = (k_r == K_LAST);
          last_row_s = (k_r == K_LAST) && (j_r == N_LAST);
          last_mat_s = (k_r == K_LAST) && (j_r == N_LAST) && (i_r == M_LAST);
          if (k_r == K_LAST) begin
            k_s = {KW{1'b0}};
            if (j_r == N_LAST) begin
              j_s = {NW{1'b0}};
              if (i_r == M_LAST) begin
                i_s     = {MW{1'b0}};
                state_s = LOAD_B;
              end else begin
                i_s     = i_r + MW'(1);
                state_s = LOAD_A;
              end
            end else begin
              j_s = j_r + NW'(1);
            end
          end else begin
            k_s = k_r + KW'(1);
          end
        end else begin
          valid_s = valid_r;
        end
      end

      default: begin
        state_s  = LOAD_B;
        wr_idx_s = {WW{1'b0}};
        valid_s  = 1'b0;
      end
    endcase
  end

  // State, counters and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= LOAD_B;
      wr_idx_r   <= {WW{1'b0}};
      k_r        <= {KW{1'b0}};
      j_r        <= {NW{1'b0}};
      i_r        <= {MW{1'b0}};
      valid_r    <= 1'b0;
      data_a_r   <= {DATA_W{1'b0}};
      data_b_r   <= {DATA_W{1'b0}};
      last_k_r   <= 1'b0;
      last_row_r <= 1'b0;
      last_mat_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      wr_idx_r   <= wr_idx_s;
      k_r        <= k_s;
      j_r        <= j_s;
      i_r        <= i_s;
      valid_r    <= valid_s;
      data_a_r   <= data_a_s;
      data_b_r   <= data_b_s;
      last_k_r   <= last_k_s;
      last_row_r <= last_row_s;
      last_mat_r <= last_mat_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign valid_out = valid_r;
  assign data_a    = data_a_r;
  assign data_b    = data_b_r;
  assign last_k    = last_k_r;
  assign last_row  = last_row_r;
  assign last_mat  = last_mat_r;

endmodule
